// File: rtl/mmu_pkg.sv
// mmu_pkg: types and constants shared by the TLB, CP0 and the pipeline.
//
// Contents:
//   - tlb_page_t / tlb_entry_t : one TLB entry (VPN2 pair mapping two 4 KB pages)
//   - tlb_exc_t                : per-port translation exception flags
//   - tlb_type_t               : decoded TLB instruction strobe from CP0
//   - mmu_resp_t               : TLBP/TLBR result latched by CP0
//   - xlate_t                  : one port's translation result
//   - segment decode constants, CCA_CACHED
//   - helpers converting between EntryLo layout and stored pages, and the
//     per-port translation rule (segment decode + exception priority)
package mmu_pkg;

    // Segment decode on vaddr[31:29].
    localparam logic [2:0]  SEG_KSEG0     = 3'b100;
    localparam logic [2:0]  SEG_KSEG1     = 3'b101;
    localparam logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF;

    // Cache coherency attribute meaning "cacheable"; anything else bypasses.
    localparam logic [2:0]  CCA_CACHED    = 3'd3;

    // Miss answer for TLBP: probe-failure bit set, index bits zero.
    localparam logic [31:0] PROBE_MISS    = 32'h8000_0000;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    typedef struct packed {
        logic refill;
        logic invalid;
        logic modified;
    } tlb_exc_t;

    typedef enum logic [2:0] {
        TLB_NONE = 3'd0,
        TLBP     = 3'd1,
        TLBR     = 3'd2,
        TLBWI    = 3'd3,
        TLBWR    = 3'd4
    } tlb_type_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
    } mmu_resp_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        tlb_exc_t    exc;
    } xlate_t;

    // EntryLo[25:1] -> stored page (pfn, c, d, v). G is handled per entry.
    function automatic tlb_page_t lo_to_page(input logic [24:0] lo_bits);
        tlb_page_t p;
        p.pfn = lo_bits[24:5];
        p.c   = lo_bits[4:2];
        p.d   = lo_bits[1];
        p.v   = lo_bits[0];
        return p;
    endfunction

    // Stored page + entry G -> EntryLo image as CP0 expects it on TLBR.
    function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
        return {6'b0, p.pfn, p.c, p.d, p.v, g};
    endfunction

    // One port's translation: unmapped segments bypass the TLB and never
    // raise exceptions; mapped addresses raise at most one flag with
    // priority refill > invalid > modified.
    function automatic xlate_t translate(input logic [31:0] vaddr,
                                         input logic [2:0]  k0,
                                         input logic        hit,
                                         input tlb_page_t   page,
                                         input logic        store);
        xlate_t r;
        r = '0;
        if (vaddr[31:29] == SEG_KSEG0) begin
            r.paddr    = vaddr & UNMAPPED_MASK;
            r.uncached = (k0 != CCA_CACHED);
        end else if (vaddr[31:29] == SEG_KSEG1) begin
            r.paddr    = vaddr & UNMAPPED_MASK;
            r.uncached = 1'b1;
        end else begin
            r.paddr    = {page.pfn, vaddr[11:0]};
            r.uncached = (page.c != CCA_CACHED);
            if (!hit) begin
                r.exc.refill = 1'b1;
            end else if (!page.v) begin
                r.exc.invalid = 1'b1;
            end else if (store && !page.d) begin
                r.exc.modified = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: purely combinational associative matcher over the TLB array.
//
// Ports:
//   vpn2    in  19        virtual page-pair number to match
//   asid    in  8         current address-space id (ignored for global entries)
//   odd     in  1         selects the odd page (vaddr[12]) of the matching pair
//   entries in  ENTRIES x tlb_entry_t  the whole TLB contents
//   hit     out 1         at least one entry matched
//   idx     out IDX_W     index of the matching entry (lowest index wins)
//   page    out tlb_page_t  selected page of the matching entry, zero on miss
module tlb_lookup
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [18:0]      vpn2,
    input  logic [7:0]       asid,
    input  logic             odd,
    input  tlb_entry_t       entries [ENTRIES],
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output tlb_page_t        page
);

    // Scan from the top down so that the last assignment made is the
    // lowest matching index, which gives lowest-index priority on
    // multiple hits without a separate priority encoder.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        page = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if ((entries[i].vpn2 == vpn2) &&
                (entries[i].g || (entries[i].asid == asid))) begin
                hit  = 1'b1;
                idx  = IDX_W'(i);
                page = odd ? entries[i].p1 : entries[i].p0;
            end
        end
    end

endmodule

// File: rtl/tlb.sv
// tlb: joint MIPS TLB downstream of CP0.
//
// Translates fetch (i_*) and data (d_*) virtual addresses, executes the
// TLBP/TLBR/TLBWI/TLBWR commands decoded by CP0, and owns the Random counter.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req, i_vaddr             fetch translation request / virtual address
//   d_req, d_vaddr, d_write    data translation request / address / store
//   i_paddr, i_uncached        fetch result, registered, held between requests
//   d_paddr, d_uncached        data result, registered, held between requests
//   i_tlb_exc, d_tlb_exc       {refill, invalid, modified} per port
//   tlb_type                   one-cycle TLB command strobe
//   entry_hi, entry_lo0/1      CP0 EntryHi / EntryLo0 / EntryLo1
//   index                      CP0 Index (low IDX_W bits select the entry)
//   wired, wired_we            CP0 Wired value and its write strobe
//   k0                         Config0.K0 (kseg0 cacheability)
//   mmu_resp, mmu_resp_valid   TLBP/TLBR result and its one-cycle pulse
//   random                     Random register, zero-extended
//
// Handshake: there is no backpressure anywhere. i_req/d_req are sampled on
// every rising edge; a request present in cycle N updates that port's
// outputs at the edge ending cycle N. tlb_type is a single-cycle strobe;
// TLBP/TLBR in cycle N raise mmu_resp_valid for exactly cycle N+1 and CP0
// must latch mmu_resp then. mmu_resp keeps its old value otherwise.
module tlb
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    input  logic        d_write,

    output logic [31:0] i_paddr,
    output logic        i_uncached,
    output tlb_exc_t    i_tlb_exc,
    output logic [31:0] d_paddr,
    output logic        d_uncached,
    output tlb_exc_t    d_tlb_exc,

    input  tlb_type_t   tlb_type,
    input  logic [31:0] entry_hi,
    input  logic [31:0] entry_lo0,
    input  logic [31:0] entry_lo1,
    input  logic [31:0] index,
    input  logic [31:0] wired,
    input  logic        wired_we,
    input  logic [2:0]  k0,

    output mmu_resp_t   mmu_resp,
    output logic        mmu_resp_valid,
    output logic [31:0] random
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(ENTRIES - 1);

    tlb_entry_t       tlb_q [ENTRIES];
    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] random_d;
    logic [IDX_W-1:0] wired_idx;
    logic [IDX_W-1:0] cmd_idx;

    assign wired_idx = wired[IDX_W-1:0];
    assign cmd_idx   = index[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Matchers: fetch, data and probe each get their own copy so all three
    // can be resolved in the same cycle.
    // ------------------------------------------------------------------
    logic             i_hit, d_hit, p_hit;
    logic [IDX_W-1:0] i_idx_unused, d_idx_unused, p_idx;
    tlb_page_t        i_page, d_page, p_page_unused;

    tlb_lookup #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_lookup_i (
        .vpn2    (i_vaddr[31:13]),
        .asid    (entry_hi[7:0]),
        .odd     (i_vaddr[12]),
        .entries (tlb_q),
        .hit     (i_hit),
        .idx     (i_idx_unused),
        .page    (i_page)
    );

    tlb_lookup #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_lookup_d (
        .vpn2    (d_vaddr[31:13]),
        .asid    (entry_hi[7:0]),
        .odd     (d_vaddr[12]),
        .entries (tlb_q),
        .hit     (d_hit),
        .idx     (d_idx_unused),
        .page    (d_page)
    );

    // TLBP only needs hit/index; the page half is irrelevant.
    tlb_lookup #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_lookup_p (
        .vpn2    (entry_hi[31:13]),
        .asid    (entry_hi[7:0]),
        .odd     (1'b0),
        .entries (tlb_q),
        .hit     (p_hit),
        .idx     (p_idx),
        .page    (p_page_unused)
    );

    // ------------------------------------------------------------------
    // Translation result registers
    // ------------------------------------------------------------------
    xlate_t i_x, d_x;

    assign i_x = translate(i_vaddr, k0, i_hit, i_page, 1'b0);
    assign d_x = translate(d_vaddr, k0, d_hit, d_page, d_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            i_paddr    <= '0;
            i_uncached <= 1'b0;
            i_tlb_exc  <= '0;
        end else if (i_req) begin
            i_paddr    <= i_x.paddr;
            i_uncached <= i_x.uncached;
            i_tlb_exc  <= i_x.exc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_paddr    <= '0;
            d_uncached <= 1'b0;
            d_tlb_exc  <= '0;
        end else if (d_req) begin
            d_paddr    <= d_x.paddr;
            d_uncached <= d_x.uncached;
            d_tlb_exc  <= d_x.exc;
        end
    end

    // ------------------------------------------------------------------
    // Random counter: counts down through the non-wired slots. When Wired
    // covers every slot but the top one, the counter parks at the top.
    // ------------------------------------------------------------------
    always_comb begin
        random_d = random_q - IDX_W'(1);
        if (wired_we || (wired_idx == RAND_TOP) || (random_q <= wired_idx)) begin
            random_d = RAND_TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            random_q <= RAND_TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random = {{(32 - IDX_W){1'b0}}, random_q};

    // ------------------------------------------------------------------
    // Entry writes (TLBWI / TLBWR). Both take effect at the edge ending the
    // command cycle, so same-cycle lookups still see the old entry.
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    tlb_entry_t       wr_entry;

    always_comb begin
        wr_en         = (tlb_type == TLBWI) || (tlb_type == TLBWR);
        wr_idx        = (tlb_type == TLBWR) ? random_q : cmd_idx;
        wr_entry      = '0;
        wr_entry.vpn2 = entry_hi[31:13];
        wr_entry.asid = entry_hi[7:0];
        // An entry is global only if both halves say so.
        wr_entry.g    = entry_lo0[0] & entry_lo1[0];
        wr_entry.p0   = lo_to_page(entry_lo0[25:1]);
        wr_entry.p1   = lo_to_page(entry_lo1[25:1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tlb_q[i] <= '0;
            end
        end else if (wr_en) begin
            tlb_q[wr_idx] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // TLBP / TLBR response. TLBP refreshes only the index field and TLBR
    // only the entry fields, mirroring which CP0 registers each one loads.
    // ------------------------------------------------------------------
    tlb_entry_t rd_entry;

    assign rd_entry = tlb_q[cmd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            mmu_resp       <= '0;
            mmu_resp_valid <= 1'b0;
        end else begin
            mmu_resp_valid <= (tlb_type == TLBP) || (tlb_type == TLBR);
            if (tlb_type == TLBP) begin
                mmu_resp.index <= p_hit ? 32'(p_idx) : PROBE_MISS;
            end
            if (tlb_type == TLBR) begin
                mmu_resp.entry_hi  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                mmu_resp.entry_lo0 <= page_to_lo(rd_entry.p0, rd_entry.g);
                mmu_resp.entry_lo1 <= page_to_lo(rd_entry.p1, rd_entry.g);
            end
        end
    end

    // CP0 register fields this block has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{entry_hi[12:8], entry_lo0[31:26], entry_lo1[31:26],
                             index[31:IDX_W], wired[31:IDX_W]};

endmodule

// File: tb/tb_tlb.sv
// tb_tlb: self-checking bench for the tlb block.
module tb_tlb;
    import mmu_pkg::*;

    localparam int ENT = 16;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk;
    logic        reset;
    logic        i_req, d_req, d_write;
    logic [31:0] i_vaddr, d_vaddr;
    logic [31:0] i_paddr, d_paddr;
    logic        i_uncached, d_uncached;
    tlb_exc_t    i_tlb_exc, d_tlb_exc;
    tlb_type_t   tlb_type;
    logic [31:0] entry_hi, entry_lo0, entry_lo1, index, wired;
    logic        wired_we;
    logic [2:0]  k0;
    mmu_resp_t   mmu_resp;
    logic        mmu_resp_valid;
    logic [31:0] random;

    tlb #(.ENTRIES(ENT)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_vaddr        (i_vaddr),
        .d_req          (d_req),
        .d_vaddr        (d_vaddr),
        .d_write        (d_write),
        .i_paddr        (i_paddr),
        .i_uncached     (i_uncached),
        .i_tlb_exc      (i_tlb_exc),
        .d_paddr        (d_paddr),
        .d_uncached     (d_uncached),
        .d_tlb_exc      (d_tlb_exc),
        .tlb_type       (tlb_type),
        .entry_hi       (entry_hi),
        .entry_lo0      (entry_lo0),
        .entry_lo1      (entry_lo1),
        .index          (index),
        .wired          (wired),
        .wired_we       (wired_we),
        .k0             (k0),
        .mmu_resp       (mmu_resp),
        .mmu_resp_valid (mmu_resp_valid),
        .random         (random)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Counters and compare helpers
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the TLB as plain arrays of decoded fields
    // ------------------------------------------------------------------
    logic [18:0] m_vpn2 [ENT];
    logic [7:0]  m_asid [ENT];
    logic        m_g    [ENT];
    logic [19:0] m_pfn  [ENT][2];
    logic [2:0]  m_c    [ENT][2];
    logic        m_d    [ENT][2];
    logic        m_v    [ENT][2];
    int          m_rand;

    typedef struct packed {
        logic [31:0] paddr;
        logic        unc;
        logic [2:0]  exc;       // {refill, invalid, modified}
        logic        chk_addr;  // paddr/uncached only meaningful without exception
    } xexp_t;

    typedef struct packed {
        logic        is_p;
        logic [31:0] index;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } rexp_t;

    xexp_t exp_i_q [$];
    xexp_t exp_d_q [$];
    rexp_t exp_r_q [$];

    task automatic model_clear();
        for (int e = 0; e < ENT; e++) begin
            m_vpn2[e] = '0;
            m_asid[e] = '0;
            m_g[e]    = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_pfn[e][p] = '0;
                m_c[e][p]   = '0;
                m_d[e][p]   = 1'b0;
                m_v[e][p]   = 1'b0;
            end
        end
    endtask

    function automatic int model_find(input logic [18:0] vpn2, input logic [7:0] asid);
        for (int e = 0; e < ENT; e++) begin
            if (m_vpn2[e] == vpn2 && (m_g[e] || m_asid[e] == asid)) return e;
        end
        return -1;
    endfunction

    function automatic xexp_t model_xlate(input logic [31:0] va, input bit is_d, input bit wr);
        xexp_t r;
        int    e;
        int    p;
        r = '0;
        r.chk_addr = 1'b1;
        if (va >= 32'h8000_0000 && va <= 32'h9FFF_FFFF) begin
            r.paddr = va - 32'h8000_0000;
            r.unc   = (k0 != 3'd3);
        end else if (va >= 32'hA000_0000 && va <= 32'hBFFF_FFFF) begin
            r.paddr = va - 32'hA000_0000;
            r.unc   = 1'b1;
        end else begin
            e = model_find(va[31:13], entry_hi[7:0]);
            p = int'(va[12]);
            if (e < 0) begin
                r.exc = 3'b100;
                r.chk_addr = 1'b0;
            end else if (!m_v[e][p]) begin
                r.exc = 3'b010;
                r.chk_addr = 1'b0;
            end else if (is_d && wr && !m_d[e][p]) begin
                r.exc = 3'b001;
                r.chk_addr = 1'b0;
            end else begin
                r.paddr = m_pfn[e][p] * 32'd4096 + 32'(va[11:0]);
                r.unc   = (m_c[e][p] != 3'd3);
            end
        end
        return r;
    endfunction

    function automatic rexp_t model_probe();
        rexp_t r;
        int    e;
        r = '0;
        r.is_p = 1'b1;
        e = model_find(entry_hi[31:13], entry_hi[7:0]);
        r.index = (e < 0) ? 32'h8000_0000 : 32'(e);
        return r;
    endfunction

    function automatic logic [31:0] model_lo(input int e, input int p);
        return {6'b0, m_pfn[e][p], m_c[e][p], m_d[e][p], m_v[e][p], m_g[e]};
    endfunction

    function automatic rexp_t model_read(input int e);
        rexp_t r;
        r = '0;
        r.hi  = {m_vpn2[e], 5'b0, m_asid[e]};
        r.lo0 = model_lo(e, 0);
        r.lo1 = model_lo(e, 1);
        return r;
    endfunction

    task automatic model_write(input int e);
        m_vpn2[e]   = entry_hi[31:13];
        m_asid[e]   = entry_hi[7:0];
        m_g[e]      = entry_lo0[0] & entry_lo1[0];
        m_pfn[e][0] = entry_lo0[25:6];
        m_c[e][0]   = entry_lo0[5:3];
        m_d[e][0]   = entry_lo0[2];
        m_v[e][0]   = entry_lo0[1];
        m_pfn[e][1] = entry_lo1[25:6];
        m_c[e][1]   = entry_lo1[5:3];
        m_d[e][1]   = entry_lo1[2];
        m_v[e][1]   = entry_lo1[1];
    endtask

    // Random register: counts down from the top slot, reloading once it has
    // shown a value at or below Wired; a Wired write or a full Wired range
    // pins it to the top slot.
    always @(posedge clk) begin
        if (reset || wired_we || int'(wired[3:0]) >= ENT - 1 || m_rand <= int'(wired[3:0])) begin
            m_rand = ENT - 1;
        end else begin
            m_rand = m_rand - 1;
        end
    end

    // ------------------------------------------------------------------
    // Driver: one cycle of stimulus, expectations pushed at issue time
    // ------------------------------------------------------------------
    task automatic cycle(input logic ireq, input logic [31:0] iva,
                         input logic dreq, input logic [31:0] dva, input logic dw,
                         input tlb_type_t t);
        i_req    = ireq;
        i_vaddr  = iva;
        d_req    = dreq;
        d_vaddr  = dva;
        d_write  = dw;
        tlb_type = t;
        if (ireq) exp_i_q.push_back(model_xlate(iva, 1'b0, 1'b0));
        if (dreq) exp_d_q.push_back(model_xlate(dva, 1'b1, dw));
        case (t)
            TLBP:    exp_r_q.push_back(model_probe());
            TLBR:    exp_r_q.push_back(model_read(int'(index[3:0])));
            TLBWI:   model_write(int'(index[3:0]));
            TLBWR:   model_write(m_rand);
            default: ;
        endcase
        @(posedge clk);
        #1;
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_write  = 1'b0;
        tlb_type = TLB_NONE;
        wired_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLB_NONE);
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    logic  i_chk = 1'b0, d_chk = 1'b0, r_chk = 1'b0;
    xexp_t cur_i, cur_d;

    always @(posedge clk) begin
        i_chk <= i_req && !reset;
        d_chk <= d_req && !reset;
        r_chk <= (tlb_type == TLBP || tlb_type == TLBR) && !reset;
    end

    task automatic cmp_x(input string port, input xexp_t e, input logic [31:0] pa,
                         input logic unc, input logic [2:0] exc);
        check32({port, "_exc"}, 32'(exc), 32'(e.exc));
        if (e.chk_addr) begin
            check32({port, "_paddr"}, pa, e.paddr);
            check32({port, "_uncached"}, 32'(unc), 32'(e.unc));
        end
    endtask

    // Outputs are compared every cycle: against the newest expectation when
    // a result is due, otherwise against the held previous result.
    always @(negedge clk) begin
        if (reset) begin
            cur_i = '0;
            cur_i.chk_addr = 1'b1;
            cur_d = cur_i;
        end else begin
            if (i_chk) begin
                if (exp_i_q.size() == 0) check32("i_queue_empty", 32'd1, 32'd0);
                else cur_i = exp_i_q.pop_front();
            end
            if (d_chk) begin
                if (exp_d_q.size() == 0) check32("d_queue_empty", 32'd1, 32'd0);
                else cur_d = exp_d_q.pop_front();
            end
            cmp_x("i", cur_i, i_paddr, i_uncached, i_tlb_exc);
            cmp_x("d", cur_d, d_paddr, d_uncached, d_tlb_exc);
        end
    end

    always @(negedge clk) begin
        rexp_t e;
        if (!reset) begin
            check32("resp_valid", 32'(mmu_resp_valid), 32'(r_chk));
            check32("random", random, 32'(m_rand));
            if (r_chk) begin
                if (exp_r_q.size() == 0) begin
                    check32("resp_queue_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_r_q.pop_front();
                    if (e.is_p) begin
                        check32("tlbp_index", mmu_resp.index, e.index);
                    end else begin
                        check32("tlbr_hi", mmu_resp.entry_hi, e.hi);
                        check32("tlbr_lo0", mmu_resp.entry_lo0, e.lo0);
                        check32("tlbr_lo1", mmu_resp.entry_lo1, e.lo1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    function automatic logic [31:0] pick_va();
        logic [18:0] v;
        v = 19'h200 + 19'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       return {3'b100, 29'($urandom)};
            1:       return {3'b101, 29'($urandom)};
            2:       return {v, 13'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    int          seq [14] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 15, 14};
    int          widx;
    int          r;
    tlb_type_t   t;

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_write = 1'b0;
        tlb_type = TLB_NONE;
        entry_hi = '0; entry_lo0 = '0; entry_lo1 = '0; index = '0;
        wired = '0; wired_we = 1'b0; k0 = 3'd3;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check32("rst_random", random, 32'd15);
        check32("rst_resp_valid", 32'(mmu_resp_valid), 32'd0);
        check32("rst_resp_index", mmu_resp.index, 32'd0);
        check32("rst_resp_lo0", mmu_resp.entry_lo0, 32'd0);
        check32("rst_i_paddr", i_paddr, 32'd0);
        check32("rst_d_exc", 32'(d_tlb_exc), 32'd0);

        // Unmapped segments
        cycle(1'b1, 32'h8000_1234, 1'b1, 32'hBFC0_0000, 1'b0, TLB_NONE);
        check32("kseg0_paddr", i_paddr, 32'h0000_1234);
        check32("kseg0_uncached", 32'(i_uncached), 32'd0);
        check32("kseg0_exc", 32'(i_tlb_exc), 32'd0);
        check32("kseg1_paddr", d_paddr, 32'h1FC0_0000);
        check32("kseg1_uncached", 32'(d_uncached), 32'd1);

        // TLBWI and mapped lookups (even / odd page)
        entry_hi = 32'h0040_2011; entry_lo0 = 32'h0000_0C5E; entry_lo1 = 32'h0000_0C9F;
        index = 32'd5;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBWI);
        cycle(1'b1, 32'h0040_2ABC, 1'b0, 32'h0, 1'b0, TLB_NONE);
        check32("map_even_paddr", i_paddr, 32'h0003_1ABC);
        check32("map_even_uncached", 32'(i_uncached), 32'd0);
        check32("map_even_exc", 32'(i_tlb_exc), 32'd0);
        cycle(1'b1, 32'h0040_3ABC, 1'b0, 32'h0, 1'b0, TLB_NONE);
        check32("map_odd_paddr", i_paddr, 32'h0003_2ABC);

        // Data-side exceptions
        cycle(1'b0, 32'h0, 1'b1, 32'h0040_2000, 1'b1, TLB_NONE);
        check32("store_dirty_exc", 32'(d_tlb_exc), 32'd0);
        entry_lo0 = 32'h0000_0C5A;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBWI);
        cycle(1'b0, 32'h0, 1'b1, 32'h0040_2000, 1'b1, TLB_NONE);
        check32("modified_exc", 32'(d_tlb_exc), 32'h1);
        entry_lo0 = 32'h0000_0C58;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBWI);
        cycle(1'b0, 32'h0, 1'b1, 32'h0040_2000, 1'b1, TLB_NONE);
        check32("invalid_exc", 32'(d_tlb_exc), 32'h2);
        cycle(1'b0, 32'h0, 1'b1, 32'h0050_0000, 1'b0, TLB_NONE);
        check32("refill_exc", 32'(d_tlb_exc), 32'h4);

        // TLBP hit / miss, TLBR
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBP);
        check32("tlbp_hit_index", mmu_resp.index, 32'd5);
        check32("tlbp_valid", 32'(mmu_resp_valid), 32'd1);
        idle(1);
        check32("tlbp_valid_drop", 32'(mmu_resp_valid), 32'd0);
        entry_hi = 32'h0040_2022;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBP);
        check32("tlbp_miss_index", mmu_resp.index, 32'h8000_0000);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBR);
        check32("tlbr_hi5", mmu_resp.entry_hi, 32'h0040_2011);
        check32("tlbr_lo0_5", mmu_resp.entry_lo0, 32'h0000_0C58);
        check32("tlbr_lo1_5", mmu_resp.entry_lo1, 32'h0000_0C9E);

        // Write and lookup in the same cycle see the old contents
        entry_hi = 32'h0060_0033; entry_lo0 = 32'h0000_0C5E; entry_lo1 = 32'h0000_0C9F;
        index = 32'd7;
        cycle(1'b1, 32'h0060_0000, 1'b0, 32'h0, 1'b0, TLBWI);
        check32("same_cycle_exc", 32'(i_tlb_exc), 32'h4);
        cycle(1'b1, 32'h0060_0000, 1'b0, 32'h0, 1'b0, TLB_NONE);
        check32("next_cycle_exc", 32'(i_tlb_exc), 32'h0);
        check32("next_cycle_paddr", i_paddr, 32'h0003_1000);

        // Random sequence with Wired = 4, then a mid-count Wired write
        wired = 32'd4; wired_we = 1'b1;
        idle(1);
        for (int k = 0; k < 14; k++) begin
            check32("wired4_seq", random, 32'(seq[k]));
            idle(1);
        end
        wired_we = 1'b1;
        idle(1);
        check32("wired_we_reload", random, 32'd15);

        // Wired covering everything pins Random at the top
        wired = 32'd15; wired_we = 1'b1;
        idle(1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check32("wired15_hold", random, 32'd15);
        end
        wired = 32'd4; wired_we = 1'b1;
        idle(3);

        // TLBWR lands in the slot Random showed that cycle
        entry_hi = 32'h0070_0044; entry_lo0 = 32'h0000_0C5F; entry_lo1 = 32'h0000_0C9F;
        widx = m_rand;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBWR);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, TLBP);
        check32("tlbwr_probe", mmu_resp.index, 32'(widx));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30) entry_hi = {19'h200 + 19'($urandom_range(0, 3)), 5'($urandom),
                                    ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h22};
            entry_lo0 = $urandom | (($urandom_range(0, 9) < 7) ? 32'h2 : 32'h0);
            entry_lo1 = $urandom | (($urandom_range(0, 9) < 7) ? 32'h2 : 32'h0);
            index     = $urandom;
            k0        = 3'($urandom_range(2, 3));
            if (r >= 95) begin
                wired    = 32'($urandom_range(0, 15));
                wired_we = 1'b1;
            end
            r = $urandom_range(0, 39);
            if (r < 6)       t = TLBWI;
            else if (r < 10) t = TLBWR;
            else if (r < 15) t = TLBP;
            else if (r < 20) t = TLBR;
            else             t = TLB_NONE;
            cycle(1'($urandom_range(0, 1)), pick_va(), 1'($urandom_range(0, 1)), pick_va(),
                  1'($urandom_range(0, 1)), t);
        end
        idle(3);

        // Reset arriving with a TLBP strobe drops its response
        tlb_type = TLBP;
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        tlb_type = TLB_NONE;
        reset = 1'b0;
        check32("midrst_valid", 32'(mmu_resp_valid), 32'd0);
        check32("midrst_index", mmu_resp.index, 32'd0);
        check32("midrst_random", random, 32'd15);
        idle(1);
        check32("midrst_valid_later", 32'(mmu_resp_valid), 32'd0);
        entry_hi = 32'h0040_2011;
        cycle(1'b1, 32'h0040_2ABC, 1'b0, 32'h0, 1'b0, TLB_NONE);
        check32("cleared_refill", 32'(i_tlb_exc), 32'h4);
        idle(2);

        check32("drain_i", 32'(exp_i_q.size()), 32'd0);
        check32("drain_d", 32'(exp_d_q.size()), 32'd0);
        check32("drain_resp", 32'(exp_r_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
